instr_queue: RTL and testbench
==============================

# instr_queue

Decoupling FIFO on the consumer side of the fetch stage. Accepts one {PC, instruction} fetch packet per cycle from fetch, holds up to DEPTH packets in order, and presents the oldest to decode. Valid/ready handshake on both sides. A flush input discards all contents on branch redirect. Backpressure (`enq_ready` low) is what fetch uses to hold `pc_write`.

## Interface
- `ADDR_WIDTH`, 12: PC width in bits.
- `INSTR_WIDTH`, 32: instruction width in bits.
- `DEPTH`, 4: number of entries; power of two, at least 2.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all entries.
- `enq_valid`  in  1  fetch presents a packet.
- `enq_ready`  out  1  queue can accept a packet this cycle.
- `enq_pc`  in  ADDR_WIDTH  PC of the incoming packet.
- `enq_instr`  in  INSTR_WIDTH  instruction of the incoming packet.
- `deq_valid`  out  1  head entry is available.
- `deq_ready`  in  1  decode consumes the head this cycle.
- `deq_pc`  out  ADDR_WIDTH  PC of the head entry.
- `deq_instr`  out  INSTR_WIDTH  instruction of the head entry.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Enqueue fires when `enq_valid && enq_ready`. The packet is written at `wr_ptr`, and `wr_ptr` increments.
- Dequeue fires when `deq_valid && deq_ready`. `rd_ptr` increments.
- `enq_ready = (count != DEPTH)`. It depends only on registered state and has no combinational path from `deq_ready`. Full with `deq_ready=1`: the enqueue is still refused that cycle.
- `deq_valid = (count != 0)`.
- `deq_pc` and `deq_instr` show the entry at `rd_ptr` when `deq_valid=1`, and are forced to 0 when `deq_valid=0`.
- Count update:
  - enqueue only: +1
  - dequeue only: −1
  - both: unchanged
  - neither: unchanged
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally. Full and empty are distinguished by `count`, not by pointer compare.
- Flush:
  - Next cycle, `rd_ptr`, `wr_ptr` and `count` are all 0.
  - Any same-cycle enqueue or dequeue is discarded. Flush has priority.
  - Storage contents are not cleared.
- Reset (`reset_n` low, asynchronous): pointers and `count` go to 0. Reset values of outputs: `deq_valid=0`, `deq_pc=0`, `deq_instr=0`, `enq_ready=1`, `count=0`. The storage array is not reset.
- Reset mid-operation: all entries are lost. No partial packet survives.
- `enq_valid` low: `enq_pc` and `enq_instr` are don't-care.
- Enqueue with `enq_ready` low: ignored. Fetch must hold the packet.

## Timing
- Latency: a packet enqueued at edge N is visible as `deq_valid=1` after edge N, i.e. in the next cycle. There is no same-cycle bypass when empty.
- Throughput: one enqueue and one dequeue per cycle sustained, when neither full nor empty.
- `enq_ready` falls the cycle after the DEPTH-th outstanding enqueue. It rises the cycle after the first dequeue from full.
- Flush asserted at edge N: after edge N, `deq_valid=0`, `enq_ready=1` and `count=0`. An enqueue is accepted from edge N+1.
- All outputs are registered state or simple decodes of registered state.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_WIDTH` and `INSTR_WIDTH` constants.
  - Typedef `fetch_pkt_t` = {pc, instr}, used by the fetch buffer and by this block.
- One sub-module, `instr_queue_mem`: a DEPTH × (`ADDR_WIDTH` + `INSTR_WIDTH`) register array with one synchronous write port and one asynchronous read port, no reset.
- Pointers, count and flush logic live in the top level.

## Test plan
- Reset, then enqueue PC 0x000/instr 0x00000013 at edge 1 with `deq_ready=0` → cycle after edge 1: `deq_valid=1`, `deq_pc=0x000`, `deq_instr=0x00000013`, `count=1`.
- Enqueue PCs 0x000, 0x004, 0x008, 0x00C back-to-back with `deq_ready=0` → `count=4`, `enq_ready=0`. A fifth packet at 0x010 is refused and `count` stays 4. Dequeue once → `enq_ready=1` next cycle, and 0x010 is accepted.
- Continuous enqueue and dequeue for 10 packets, PC 0x000..0x024 → dequeued PCs are in order with no gaps, `count` stays 1, and pointers wrap past DEPTH correctly.
- Full queue with `flush=1`, `enq_valid=1` and `deq_ready=1` in the same cycle → next cycle `count=0`, `deq_valid=0`, `enq_ready=1`, and the flushed and concurrent packets never appear at dequeue.
- Assert `reset_n` low asynchronously mid-cycle with 3 entries queued → outputs go to their reset values immediately, without waiting for `clk`. After release, the first enqueued PC 0x100 is the first dequeued.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC/instruction widths and the fetch packet
// exchanged between fetch, the instruction queue and decode.
package cpu_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int INSTR_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/instr_queue_mem.sv
// Storage for the instruction queue: DEPTH fetch packets, one synchronous
// write port and one asynchronous read port.
module instr_queue_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  fetch_pkt_t       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output fetch_pkt_t       rd_data
);

    fetch_pkt_t r_mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the queue's count,
    // so clearing it would only add reset fan-out to every storage bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling FIFO: in-order {pc, instr} packets with
// valid/ready on both sides and a flush for branch redirects.
module instr_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [ADDR_WIDTH-1:0]    enq_pc,
    input  logic [INSTR_WIDTH-1:0]   enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [ADDR_WIDTH-1:0]    deq_pc,
    output logic [INSTR_WIDTH-1:0]   deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic       w_enq_fire;
    logic       w_deq_fire;
    fetch_pkt_t w_wr_pkt;
    fetch_pkt_t w_head;

    // Both ready/valid come from count alone, so no deq_ready -> enq_ready path.
    assign enq_ready  = (r_count != FULL_COUNT);
    assign deq_valid  = (r_count != '0);
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = deq_valid && deq_ready;

    assign w_wr_pkt  = '{pc: enq_pc, instr: enq_instr};
    assign deq_pc    = deq_valid ? w_head.pc    : '0;
    assign deq_instr = deq_valid ? w_head.instr : '0;
    assign count     = r_count;

    instr_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_enq_fire && !flush),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_pkt),
        .rd_addr (r_rd_ptr),
        .rd_data (w_head)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: stimulus pushes expected packets,
// a negedge monitor pops and compares on every dequeue handshake.
module tb_instr_queue;
    import cpu_pkg::*;

    logic                   clk;
    logic                   reset_n;
    logic                   flush;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [ADDR_WIDTH-1:0]  enq_pc;
    logic [INSTR_WIDTH-1:0] enq_instr;
    logic                   deq_valid;
    logic                   deq_ready;
    logic [ADDR_WIDTH-1:0]  deq_pc;
    logic [INSTR_WIDTH-1:0] deq_instr;
    logic [2:0]             count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_pkt_t sb[$];

    instr_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [ADDR_WIDTH-1:0] pc,
                             input logic [INSTR_WIDTH-1:0] instr, input logic push);
        enq_valid = v;
        enq_pc    = pc;
        enq_instr = instr;
        if (push) sb.push_back('{pc: pc, instr: instr});
    endtask

    // Monitor: a dequeue handshake sampled here completes at the next posedge.
    always @(negedge clk) begin
        if (reset_n && !flush && deq_valid && deq_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL deq_unexpected: got pc 0x%0h instr 0x%0h, no packet expected", deq_pc, deq_instr);
            end else begin
                fetch_pkt_t e;
                e = sb.pop_front();
                if (deq_pc !== e.pc || deq_instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL deq_order: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                             deq_pc, deq_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        deq_ready = 1'b0;
        drive_enq(1'b0, '0, '0, 1'b0);
        #22;
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_count",     64'(count),     64'd0);
        check("rst_deq_pc",    64'(deq_pc),    64'd0);
        check("rst_deq_instr", 64'(deq_instr), 64'd0);
        reset_n = 1'b1;
        cyc();

        // Single packet, one-cycle latency, no bypass.
        drive_enq(1'b1, 12'h000, 32'h0000_0013, 1'b1);
        cyc();
        drive_enq(1'b0, '0, '0, 1'b0);
        check("t1_deq_valid", 64'(deq_valid), 64'd1);
        check("t1_deq_pc",    64'(deq_pc),    64'h000);
        check("t1_deq_instr", 64'(deq_instr), 64'h0000_0013);
        check("t1_count",     64'(count),     64'd1);
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        check("t1_drained", 64'(count), 64'd0);

        // Fill to full, refuse fifth, dequeue once, then accept it.
        for (int i = 0; i < 4; i++) begin
            drive_enq(1'b1, 12'(4 * i), 32'h0010_0093 + 32'(i), 1'b1);
            cyc();
        end
        check("t2_full_count", 64'(count),     64'd4);
        check("t2_full_ready", 64'(enq_ready), 64'd0);
        drive_enq(1'b1, 12'h010, 32'h0020_0113, 1'b0);
        cyc();
        check("t2_refused_count", 64'(count), 64'd4);
        deq_ready = 1'b1;
        cyc();
        check("t2_full_deq_count", 64'(count),     64'd3);
        check("t2_ready_rises",    64'(enq_ready), 64'd1);
        deq_ready = 1'b0;
        drive_enq(1'b1, 12'h010, 32'h0020_0113, 1'b1);
        cyc();
        drive_enq(1'b0, '0, '0, 1'b0);
        check("t2_accept_count", 64'(count), 64'd4);
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        deq_ready = 1'b0;
        check("t2_empty", 64'(count), 64'd0);

        // Streaming: ten packets with simultaneous enqueue/dequeue.
        for (int i = 0; i < 10; i++) begin
            drive_enq(1'b1, 12'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
            deq_ready = (i != 0);
            cyc();
            check("t3_count", 64'(count), 64'd1);
        end
        drive_enq(1'b0, '0, '0, 1'b0);
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        check("t3_empty", 64'(count), 64'd0);

        // Flush a full queue with concurrent enqueue and dequeue.
        for (int i = 0; i < 4; i++) begin
            drive_enq(1'b1, 12'h080 + 12'(4 * i), 32'hB000_0000 + 32'(i), 1'b1);
            cyc();
        end
        flush     = 1'b1;
        deq_ready = 1'b1;
        drive_enq(1'b1, 12'h200, 32'hDEAD_BEEF, 1'b0);
        cyc();
        flush     = 1'b0;
        deq_ready = 1'b0;
        drive_enq(1'b0, '0, '0, 1'b0);
        sb.delete();
        check("t4_count",     64'(count),     64'd0);
        check("t4_deq_valid", 64'(deq_valid), 64'd0);
        check("t4_enq_ready", 64'(enq_ready), 64'd1);
        check("t4_deq_pc",    64'(deq_pc),    64'd0);
        drive_enq(1'b1, 12'h300, 32'hC000_0001, 1'b1);
        cyc();
        drive_enq(1'b0, '0, '0, 1'b0);
        check("t4_post_count", 64'(count), 64'd1);
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;

        // Asynchronous reset mid-cycle with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive_enq(1'b1, 12'h100 + 12'(4 * i), 32'hE000_0000 + 32'(i), 1'b1);
            cyc();
        end
        drive_enq(1'b0, '0, '0, 1'b0);
        check("t5_pre_count", 64'(count), 64'd3);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_deq_valid", 64'(deq_valid), 64'd0);
        check("t5_rst_enq_ready", 64'(enq_ready), 64'd1);
        check("t5_rst_count",     64'(count),     64'd0);
        check("t5_rst_deq_pc",    64'(deq_pc),    64'd0);
        check("t5_rst_deq_instr", 64'(deq_instr), 64'd0);
        sb.delete();
        #4;
        reset_n = 1'b1;
        cyc();
        drive_enq(1'b1, 12'h100, 32'hF000_0000, 1'b1);
        cyc();
        drive_enq(1'b1, 12'h104, 32'hF000_0001, 1'b1);
        deq_ready = 1'b1;
        cyc();
        drive_enq(1'b0, '0, '0, 1'b0);
        cyc();
        deq_ready = 1'b0;
        check("t5_final_count", 64'(count), 64'd0);

        check("sb_all_dequeued", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
